md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Sequencer and owner of the HI/LO register pair for the pipelined MIPS core's multiply/divide resource.
- Accepts multiply/divide/move-to requests from the E stage and models multi-cycle latency with a countdown counter.
- Commits results to HI/LO on completion.
- Generates the D-stage stall request for HI/LO-class instructions while the resource is occupied.
- Replaces the hazard-side busy logic with a single owned block; sits beside the ALU in E.

Parameters:
- MULT_LAT, 5, cycles busy is held for mult/multu (≥1).
- DIV_LAT, 10, cycles busy is held for div/divu (≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  E-stage request valid for op.
- op  in  4  1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; other values are no-op.
- a  in  32  rs operand (forwarded).
- b  in  32  rt operand (forwarded).
- flush  in  1  kill the E-stage request and abort any in-flight op.
- d_is_md  in  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- busy  out  1  registered; resource occupied.
- hi  out  32  current HI.
- lo  out  32  current LO.
- stall_md  out  1  combinational: d_is_md & (busy | (start & ~flush & op in 1..4)).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset, any state including mid-operation: HI=0, LO=0, busy=0, counter=0, pending=0, state IDLE.
- FSM states are IDLE and RUN.
- IDLE, start & ~flush & op in 1..4 at edge E0:
  - latch pend_hi/pend_lo from a, b.
  - load cnt=LAT-1 (MULT_LAT or DIV_LAT by op); go to RUN; busy=1 after E0.
- RUN, each edge:
  - if flush: go to IDLE, busy=0, HI/LO unchanged.
  - else if cnt==0: HI←pend_hi, LO←pend_lo, busy=0, go to IDLE.
  - else cnt←cnt-1.
- Timing: busy is high for exactly LAT cycles; the new HI/LO is visible from edge E_LAT onward, in the same cycle busy first reads 0.
- mthi/mtlo (op 5/6) in IDLE with start & ~flush: HI (resp. LO) ←a at the next edge; busy stays 0.
- start while busy, any op: ignored. The stall_md protocol makes this unreachable; the bench flags it as an error.
- flush with start in the same cycle: flush wins; start is ignored, including mthi/mtlo.
- Arithmetic:
  - mult: {HI,LO}=signed a×signed b, 64-bit.
  - multu: unsigned product, 64-bit.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (div or divu): full DIV_LAT busy period runs; HI/LO keep their previous values at completion.
- hi/lo outputs are direct register values; an mfhi/mflo in E reads them only when not stalled.
- stall_md also asserts in the start cycle itself, so a D-stage HI/LO instruction following a mult directly is held.

Decomposition:
- Shared package md_pkg:
  - op codes MD_MULT..MD_MTLO (4-bit).
  - constants MD_IDLE/MD_RUN.
  - function md_is_long(op).
- One sub-module md_arith (combinational): inputs a, b, op; outputs res_hi, res_lo, div0. Keeps the signed/unsigned and divide edge cases out of the FSM.
- Counter width is $clog2(max(MULT_LAT,DIV_LAT)).

Test Plan:
- multu a=0xFFFFFFFF b=2 at E0 -> busy=1 cycles 1..5; after E5 HI=0x00000001, LO=0xFFFFFFFE, busy=0.
- div a=0xFFFFFFF9 (-7) b=2 -> after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi a=0x12345678 then divu b=0 -> HI=0x12345678 after one edge; divu keeps busy 10 cycles; HI/LO unchanged afterwards.
- mult a=3 b=4 with d_is_md=1 held -> stall_md=1 in the start cycle and cycles 1..5, 0 in cycle 6; HI=0, LO=12.
- mult started, flush at cycle 3 -> busy=0 next edge, HI/LO keep prior values; start+flush same cycle -> no state change.
- reset asserted at cycle 2 of a div -> next edge HI=LO=0, busy=0; a subsequent mtlo 0xA writes LO=0xA.

Source files
------------

// File: rtl/md_pkg.sv
// Shared op codes, sequencer states and helpers for the multiply/divide block.
package md_pkg;

    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;

    typedef enum logic {
        MD_IDLE,
        MD_RUN
    } mdState_t;

    // Ops that occupy the resource for a multi-cycle busy period.
    function automatic logic md_is_long(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the HI/LO pair for a request.
module md_arith
    import md_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic        isSigned;
    logic        aNeg;
    logic        bNeg;
    logic [31:0] aMag;
    logic [31:0] bMag;
    logic [31:0] quotMag;
    logic [31:0] remMag;
    logic [63:0] aExt;
    logic [63:0] bExt;
    logic [63:0] prod;

    always_comb begin
        isSigned = (op == MD_MULT) || (op == MD_DIV);
        aExt     = isSigned ? {{32{a[31]}}, a} : {32'd0, a};
        bExt     = isSigned ? {{32{b[31]}}, b} : {32'd0, b};
        // Low 64 bits of the extended product equal the true signed/unsigned product.
        prod     = aExt * bExt;

        // Divide on magnitudes so overflow (MIN / -1) wraps to MIN without a special case.
        aNeg     = isSigned & a[31];
        bNeg     = isSigned & b[31];
        aMag     = aNeg ? (32'd0 - a) : a;
        bMag     = bNeg ? (32'd0 - b) : b;
        div0     = (b == '0);
        quotMag  = div0 ? '0 : (aMag / bMag);
        remMag   = div0 ? '0 : (aMag % bMag);

        if (md_is_div(op)) begin
            res_lo = (aNeg ^ bNeg) ? (32'd0 - quotMag) : quotMag;
            res_hi = aNeg ? (32'd0 - remMag) : remMag;
        end else begin
            res_lo = prod[31:0];
            res_hi = prod[63:32];
        end
    end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer: owns HI/LO, models op latency and raises the D-stage stall.
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        d_is_md,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_md
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = ($clog2(MAX_LAT) > 0) ? $clog2(MAX_LAT) : 1;

    mdState_t          state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic [31:0]       hiReg, hiNext;
    logic [31:0]       loReg, loNext;
    logic [31:0]       pendHi, pendHiNext;
    logic [31:0]       pendLo, pendLoNext;
    logic              pendKeep, pendKeepNext;

    logic [31:0]       resHi;
    logic [31:0]       resLo;
    logic              resDiv0;
    logic              accept;

    md_arith uArith (
        .a      (a),
        .b      (b),
        .op     (op),
        .res_hi (resHi),
        .res_lo (resLo),
        .div0   (resDiv0)
    );

    assign accept   = start & ~flush;
    assign busy     = (state == MD_RUN);
    assign hi       = hiReg;
    assign lo       = loReg;
    assign stall_md = d_is_md & (busy | (accept & md_is_long(op)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= MD_IDLE;
            cnt      <= '0;
            hiReg    <= '0;
            loReg    <= '0;
            pendHi   <= '0;
            pendLo   <= '0;
            pendKeep <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            hiReg    <= hiNext;
            loReg    <= loNext;
            pendHi   <= pendHiNext;
            pendLo   <= pendLoNext;
            pendKeep <= pendKeepNext;
        end
    end

    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        hiNext       = hiReg;
        loNext       = loReg;
        pendHiNext   = pendHi;
        pendLoNext   = pendLo;
        pendKeepNext = pendKeep;

        unique case (state)
            MD_IDLE: begin
                if (accept) begin
                    if (md_is_long(op)) begin
                        pendHiNext   = resHi;
                        pendLoNext   = resLo;
                        pendKeepNext = md_is_div(op) & resDiv0;
                        cntNext      = md_is_div(op) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
                        stateNext    = MD_RUN;
                    end else if (op == MD_MTHI) begin
                        hiNext = a;
                    end else if (op == MD_MTLO) begin
                        loNext = a;
                    end
                end
            end
            MD_RUN: begin
                // Flush aborts before the completion check, so a flush on the last cycle still drops the result.
                if (flush) begin
                    stateNext = MD_IDLE;
                    cntNext   = '0;
                end else if (cnt == '0) begin
                    if (!pendKeep) begin
                        hiNext = pendHi;
                        loNext = pendLo;
                    end
                    stateNext = MD_IDLE;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            default: stateNext = MD_IDLE;
        endcase
    end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed scenarios plus a randomized run against a behavioural model.
module tb_md_sched;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        d_is_md;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_md;

    int passCnt  = 0;
    int totalCnt = 0;

    logic [31:0] expHi;
    logic [31:0] expLo;

    md_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .d_is_md  (d_is_md),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .stall_md (stall_md)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        start = 1'b0; op = 4'd0; a = '0; b = '0; flush = 1'b0; d_is_md = 1'b0;
    endtask

    // Architectural result of an op computed with wide integer arithmetic.
    task automatic refResult(input logic [3:0] rop, input logic [31:0] ra, input logic [31:0] rb,
                             output logic [31:0] rhi, output logic [31:0] rlo, output bit rdiv0);
        longint      sa, sb, sq, sr;
        logic [63:0] up;
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        rdiv0 = 1'b0;
        rhi = '0; rlo = '0;
        case (rop)
            4'd1: begin sq = sa * sb; rhi = sq[63:32]; rlo = sq[31:0]; end
            4'd2: begin up = {32'd0, ra} * {32'd0, rb}; rhi = up[63:32]; rlo = up[31:0]; end
            4'd3: begin
                if (rb == 0) rdiv0 = 1'b1;
                else begin sq = sa / sb; sr = sa % sb; rlo = sq[31:0]; rhi = sr[31:0]; end
            end
            4'd4: begin
                if (rb == 0) rdiv0 = 1'b1;
                else begin rlo = ra / rb; rhi = ra % rb; end
            end
            default: ;
        endcase
    endtask

    task automatic test_reset();
        idleInputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        d_is_md = 1'b1;
        #1;
        totalCnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passCnt++;
        totalCnt++; if (hi !== 32'd0) $display("FAIL reset_hi got=%h exp=0", hi); else passCnt++;
        totalCnt++; if (lo !== 32'd0) $display("FAIL reset_lo got=%h exp=0", lo); else passCnt++;
        totalCnt++; if (stall_md !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall_md); else passCnt++;
        d_is_md = 1'b0;
        expHi = '0; expLo = '0;
    endtask

    task automatic test_multu();
        start = 1'b1; op = 4'd2; a = 32'hFFFF_FFFF; b = 32'd2;
        tick();
        idleInputs();
        for (int unsigned i = 1; i <= MULT_LAT; i++) begin
            totalCnt++; if (busy !== 1'b1) $display("FAIL multu_busy cycle=%0d got=%b exp=1", i, busy); else passCnt++;
            tick();
        end
        totalCnt++; if (busy !== 1'b0) $display("FAIL multu_done_busy got=%b exp=0", busy); else passCnt++;
        totalCnt++; if (hi !== 32'h0000_0001) $display("FAIL multu_hi got=%h exp=00000001", hi); else passCnt++;
        totalCnt++; if (lo !== 32'hFFFF_FFFE) $display("FAIL multu_lo got=%h exp=fffffffe", lo); else passCnt++;
        expHi = 32'h0000_0001; expLo = 32'hFFFF_FFFE;
    endtask

    task automatic test_div();
        start = 1'b1; op = 4'd3; a = 32'hFFFF_FFF9; b = 32'd2;
        tick();
        idleInputs();
        for (int unsigned i = 1; i <= DIV_LAT; i++) begin
            totalCnt++; if (busy !== 1'b1) $display("FAIL div_busy cycle=%0d got=%b exp=1", i, busy); else passCnt++;
            tick();
        end
        totalCnt++; if (busy !== 1'b0) $display("FAIL div_done_busy got=%b exp=0", busy); else passCnt++;
        totalCnt++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got=%h exp=fffffffd", lo); else passCnt++;
        totalCnt++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got=%h exp=ffffffff", hi); else passCnt++;

        start = 1'b1; op = 4'd3; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
        tick();
        idleInputs();
        for (int unsigned i = 1; i <= DIV_LAT; i++) tick();
        totalCnt++; if (lo !== 32'h8000_0000) $display("FAIL divovf_lo got=%h exp=80000000", lo); else passCnt++;
        totalCnt++; if (hi !== 32'h0) $display("FAIL divovf_hi got=%h exp=00000000", hi); else passCnt++;
        expHi = 32'h0; expLo = 32'h8000_0000;
    endtask

    task automatic test_mthi_divu0();
        start = 1'b1; op = 4'd5; a = 32'h1234_5678;
        tick();
        idleInputs();
        totalCnt++; if (hi !== 32'h1234_5678) $display("FAIL mthi_hi got=%h exp=12345678", hi); else passCnt++;
        totalCnt++; if (busy !== 1'b0) $display("FAIL mthi_busy got=%b exp=0", busy); else passCnt++;
        expHi = 32'h1234_5678;

        start = 1'b1; op = 4'd4; a = 32'hDEAD_BEEF; b = 32'd0;
        tick();
        idleInputs();
        for (int unsigned i = 1; i <= DIV_LAT; i++) begin
            totalCnt++; if (busy !== 1'b1) $display("FAIL divu0_busy cycle=%0d got=%b exp=1", i, busy); else passCnt++;
            tick();
        end
        totalCnt++; if (busy !== 1'b0) $display("FAIL divu0_done_busy got=%b exp=0", busy); else passCnt++;
        totalCnt++; if (hi !== expHi) $display("FAIL divu0_hi got=%h exp=%h", hi, expHi); else passCnt++;
        totalCnt++; if (lo !== expLo) $display("FAIL divu0_lo got=%h exp=%h", lo, expLo); else passCnt++;
    endtask

    task automatic test_stall();
        start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4; d_is_md = 1'b1;
        #1;
        totalCnt++; if (stall_md !== 1'b1) $display("FAIL stall_start got=%b exp=1", stall_md); else passCnt++;
        tick();
        start = 1'b0;
        for (int unsigned i = 1; i <= MULT_LAT; i++) begin
            totalCnt++; if (stall_md !== 1'b1) $display("FAIL stall_run cycle=%0d got=%b exp=1", i, stall_md); else passCnt++;
            tick();
        end
        totalCnt++; if (stall_md !== 1'b0) $display("FAIL stall_release got=%b exp=0", stall_md); else passCnt++;
        totalCnt++; if (hi !== 32'd0) $display("FAIL stall_hi got=%h exp=00000000", hi); else passCnt++;
        totalCnt++; if (lo !== 32'd12) $display("FAIL stall_lo got=%h exp=0000000c", lo); else passCnt++;
        idleInputs();
        expHi = 32'd0; expLo = 32'd12;
    endtask

    task automatic test_flush();
        start = 1'b1; op = 4'd1; a = 32'd1000; b = 32'd1000;
        tick();
        idleInputs();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        totalCnt++; if (busy !== 1'b0) $display("FAIL flush_busy got=%b exp=0", busy); else passCnt++;
        totalCnt++; if (hi !== expHi) $display("FAIL flush_hi got=%h exp=%h", hi, expHi); else passCnt++;
        totalCnt++; if (lo !== expLo) $display("FAIL flush_lo got=%h exp=%h", lo, expLo); else passCnt++;
        for (int unsigned i = 0; i < MULT_LAT; i++) tick();
        totalCnt++; if (lo !== expLo) $display("FAIL flush_late_lo got=%h exp=%h", lo, expLo); else passCnt++;

        start = 1'b1; flush = 1'b1; op = 4'd5; a = 32'hCAFE_F00D; d_is_md = 1'b1;
        #1;
        totalCnt++; if (stall_md !== 1'b0) $display("FAIL flushstart_stall_mthi got=%b exp=0", stall_md); else passCnt++;
        tick();
        totalCnt++; if (hi !== expHi) $display("FAIL flushstart_hi got=%h exp=%h", hi, expHi); else passCnt++;
        op = 4'd3; b = 32'd7;
        #1;
        totalCnt++; if (stall_md !== 1'b0) $display("FAIL flushstart_stall_div got=%b exp=0", stall_md); else passCnt++;
        tick();
        totalCnt++; if (busy !== 1'b0) $display("FAIL flushstart_busy got=%b exp=0", busy); else passCnt++;
        idleInputs();
    endtask

    task automatic test_reset_mid();
        start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
        tick();
        idleInputs();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        totalCnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else passCnt++;
        totalCnt++; if (hi !== 32'd0) $display("FAIL rstmid_hi got=%h exp=0", hi); else passCnt++;
        totalCnt++; if (lo !== 32'd0) $display("FAIL rstmid_lo got=%h exp=0", lo); else passCnt++;
        for (int unsigned i = 0; i < DIV_LAT; i++) tick();
        totalCnt++; if (lo !== 32'd0) $display("FAIL rstmid_late_lo got=%h exp=0", lo); else passCnt++;
        start = 1'b1; op = 4'd6; a = 32'hA;
        tick();
        idleInputs();
        totalCnt++; if (lo !== 32'hA) $display("FAIL rstmid_mtlo got=%h exp=0000000a", lo); else passCnt++;
        totalCnt++; if (hi !== 32'd0) $display("FAIL rstmid_mtlo_hi got=%h exp=0", hi); else passCnt++;
        expHi = 32'd0; expLo = 32'hA;
    endtask

    task automatic test_random();
        logic [3:0]  rop;
        logic [31:0] ra, rb, rhi, rlo;
        bit          rdiv0, rfl, rd, isLong, aborted;
        int unsigned lat, flushAt;
        for (int unsigned n = 0; n < 80; n++) begin
            rop = 4'($urandom_range(0, 7));
            ra  = $urandom();
            rb  = $urandom();
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) rb = 32'hFFFF_FFFF;
            rfl = ($urandom_range(0, 7) == 0);
            rd  = 1'($urandom_range(0, 1));
            isLong = (rop >= 4'd1) && (rop <= 4'd4);
            start = 1'b1; op = rop; a = ra; b = rb; flush = rfl; d_is_md = rd;
            #1;
            totalCnt++;
            if (stall_md !== (rd & ~rfl & isLong)) $display("FAIL rnd_stall_start n=%0d got=%b exp=%b", n, stall_md, rd & ~rfl & isLong);
            else passCnt++;
            tick();
            idleInputs();
            if (!rfl && isLong) begin
                refResult(rop, ra, rb, rhi, rlo, rdiv0);
                lat = (rop <= 4'd2) ? MULT_LAT : DIV_LAT;
                flushAt = $urandom_range(1, 3 * lat);
                aborted = 1'b0;
                for (int unsigned k = 1; k <= lat && !aborted; k++) begin
                    totalCnt++; if (busy !== 1'b1) $display("FAIL rnd_busy n=%0d k=%0d got=%b exp=1", n, k, busy); else passCnt++;
                    rd = 1'($urandom_range(0, 1));
                    d_is_md = rd;
                    flush = (k == flushAt);
                    #1;
                    totalCnt++; if (stall_md !== rd) $display("FAIL rnd_stall_run n=%0d k=%0d got=%b exp=%b", n, k, stall_md, rd); else passCnt++;
                    tick();
                    aborted = (k == flushAt);
                    flush = 1'b0;
                end
                if (!aborted && !rdiv0) begin
                    expHi = rhi; expLo = rlo;
                end
            end else if (!rfl && rop == 4'd5) begin
                expHi = ra;
            end else if (!rfl && rop == 4'd6) begin
                expLo = ra;
            end
            d_is_md = 1'b0;
            totalCnt++; if (busy !== 1'b0) $display("FAIL rnd_done_busy n=%0d got=%b exp=0", n, busy); else passCnt++;
            totalCnt++; if (hi !== expHi) $display("FAIL rnd_hi n=%0d op=%0d a=%h b=%h got=%h exp=%h", n, rop, ra, rb, hi, expHi); else passCnt++;
            totalCnt++; if (lo !== expLo) $display("FAIL rnd_lo n=%0d op=%0d a=%h b=%h got=%h exp=%h", n, rop, ra, rb, lo, expLo); else passCnt++;
        end
    endtask

    initial begin
        reset = 1'b1;
        idleInputs();
        test_reset();
        test_multu();
        test_div();
        test_mthi_divu0();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
